// File: rtl/index_mask_if.sv
// index_mask_if: index-beat stream in, frame mask out, for index_mask_builder
// Ports: in_valid_i/in_ready_o/in_index_i/in_last_i/target_i index stream,
//        out_valid_o/out_ready_i/out_mask_o/out_count_o/out_err_o frame result.
// slave is the builder's view, master is the producer/consumer view.
interface index_mask_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 3
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_DEPTH-1:0] in_index_i;
    logic                  in_last_i;
    logic                  target_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_mask_o;
    logic [DATA_DEPTH:0]   out_count_o;
    logic                  out_err_o;

    modport master (
        output in_valid_i, in_index_i, in_last_i, target_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_mask_o, out_count_o, out_err_o
    );

    modport slave (
        input  in_valid_i, in_index_i, in_last_i, target_i, out_ready_i,
        output in_ready_o, out_valid_o, out_mask_o, out_count_o, out_err_o
    );
endinterface

// File: rtl/index_mask_builder.sv
// index_mask_builder: builds an MSB-first polarity mask from a framed stream of bit indices
// Ports: clk, rst_n (async active-low), bus (index_mask_if.slave).
// Index k writes mask bit DATA_WIDTH-1-k to the polarity latched on the frame's first beat;
// out_count_o saturates, out_err_o flags any index >= DATA_WIDTH in the frame.
// Optional: define INDEX_MASK_BYPASS_EN to accept a new frame's beat during the output
// handshake cycle, giving zero-bubble back-to-back frames.
module index_mask_builder #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 3
) (
    input logic         clk,
    input logic         rst_n,
    index_mask_if.slave bus
);
    typedef enum logic {ACC, OUT} state_t;
    state_t                state;
    logic                  first, tgt, err, fire, in_range, use_tgt, next_err;
    logic [DATA_WIDTH-1:0] acc_mask, next_mask, out_mask;
    logic [DATA_DEPTH:0]   count, next_count, out_count;
    logic                  out_err;
`ifdef INDEX_MASK_BYPASS_EN
    assign bus.in_ready_o = (state == ACC) | bus.out_ready_i;
`else
    assign bus.in_ready_o = state == ACC;
`endif
    assign bus.out_valid_o = state == OUT;
    assign bus.out_mask_o  = out_mask;
    assign bus.out_count_o = out_count;
    assign bus.out_err_o   = out_err;
    assign fire     = bus.in_valid_i & bus.in_ready_o;
    assign in_range = {1'b0, bus.in_index_i} < (DATA_DEPTH + 1)'(DATA_WIDTH);
    assign use_tgt  = first ? bus.target_i : tgt;
    assign next_count = first ? (DATA_DEPTH + 1)'(1) : (&count ? count : count + 1'b1);
    assign next_err   = ~in_range | (~first & err);

    // out-of-range indices match no bit position, so the mask is left untouched
    always_comb begin
        next_mask = first ? {DATA_WIDTH{~bus.target_i}} : acc_mask;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (bus.in_index_i == DATA_DEPTH'(DATA_WIDTH - 1 - i)) next_mask[i] = use_tgt;
    end

    // a beat accepted together with the output handshake overrides the handshake's clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            first     <= 1'b1;
            tgt       <= 1'b0;
            acc_mask  <= '0;
            count     <= '0;
            err       <= 1'b0;
            out_mask  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                state <= ACC;
                first <= 1'b1;
                count <= '0;
                err   <= 1'b0;
            end
            if (fire) begin
                acc_mask <= next_mask;
                count    <= next_count;
                err      <= next_err;
                first    <= bus.in_last_i;
                if (first) tgt <= bus.target_i;
                if (bus.in_last_i) begin
                    state     <= OUT;
                    out_mask  <= next_mask;
                    out_count <= next_count;
                    out_err   <= next_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_index_mask_builder.sv
// tb_index_mask_builder: directed table-driven check of index_mask_builder at widths 8 and 6
module tb_index_mask_builder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, target = 1'b0, out_ready = 1'b0;
    logic [2:0] in_index = '0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    index_mask_if #(.DATA_WIDTH(8), .DATA_DEPTH(3)) b8 ();
    index_mask_if #(.DATA_WIDTH(6), .DATA_DEPTH(3)) b6 ();

    assign b8.in_valid_i = in_valid;
    assign b8.in_index_i = in_index;
    assign b8.in_last_i = in_last;
    assign b8.target_i = target;
    assign b8.out_ready_i = out_ready;
    assign b6.in_valid_i = in_valid;
    assign b6.in_index_i = in_index;
    assign b6.in_last_i = in_last;
    assign b6.target_i = target;
    assign b6.out_ready_i = out_ready;

    index_mask_builder #(.DATA_WIDTH(8), .DATA_DEPTH(3)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    index_mask_builder #(.DATA_WIDTH(6), .DATA_DEPTH(3)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    typedef struct {
        int         n;
        logic [2:0][2:0] idx;
        logic       t0, t1;
        logic [3:0] cnt;
        logic [7:0] m8;
        logic       e8;
        logic [5:0] m6;
        logic       e6;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(int n, logic [2:0] i0, logic [2:0] i1, logic [2:0] i2,
                                logic t0, logic t1, logic [3:0] cnt,
                                logic [7:0] m8, logic e8, logic [5:0] m6, logic e6);
        vec_t r;
        r.n = n;
        r.idx[0] = i0;
        r.idx[1] = i1;
        r.idx[2] = i2;
        r.t0 = t0;
        r.t1 = t1;
        r.cnt = cnt;
        r.m8 = m8;
        r.e8 = e8;
        r.m6 = m6;
        r.e6 = e6;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int n, input logic [16:0][2:0] idx, input logic t0, input logic t1);
        for (int b = 0; b < n; b++) begin
            int w = 0;
            in_valid = 1'b1;
            in_index = idx[b];
            in_last = (b == n - 1);
            target = (b == 0) ? t0 : t1;
            while (!b8.in_ready_o && w < 20) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (w == 20) chk("ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] cnt, input logic [7:0] m8,
                             input logic e8, input logic [5:0] m6, input logic e6);
        chk({tag, "_valid8"}, b8.out_valid_o, 1);
        chk({tag, "_valid6"}, b6.out_valid_o, 1);
        chk({tag, "_mask8"}, b8.out_mask_o, m8);
        chk({tag, "_count8"}, b8.out_count_o, cnt);
        chk({tag, "_err8"}, b8.out_err_o, e8);
        chk({tag, "_mask6"}, b6.out_mask_o, m6);
        chk({tag, "_count6"}, b6.out_count_o, cnt);
        chk({tag, "_err6"}, b6.out_err_o, e6);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop8", b8.out_valid_o, 0);
        chk("valid_drop6", b6.out_valid_o, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, b8.out_valid_o, 0);
        chk({tag, "_mask"}, b8.out_mask_o, 0);
        chk({tag, "_count"}, b8.out_count_o, 0);
        chk({tag, "_err"}, b8.out_err_o, 0);
        chk({tag, "_ready"}, b8.in_ready_o, 1);
        chk({tag, "_valid6"}, b6.out_valid_o, 0);
        chk({tag, "_mask6"}, b6.out_mask_o, 0);
    endtask

    initial begin
        logic [16:0][2:0] seq;
        vecs[0] = mk(2, 0, 3, 0, 1, 1, 2, 8'h90, 0, 6'h24, 0);
        vecs[1] = mk(1, 7, 0, 0, 0, 0, 1, 8'hFE, 0, 6'h3F, 1);
        vecs[2] = mk(3, 2, 2, 5, 1, 1, 3, 8'h24, 0, 6'h09, 0);
        vecs[3] = mk(2, 1, 6, 0, 1, 0, 2, 8'h42, 0, 6'h10, 1);
        vecs[4] = mk(2, 6, 1, 0, 1, 1, 2, 8'h42, 0, 6'h10, 1);
        vecs[5] = mk(1, 0, 0, 0, 1, 1, 1, 8'h80, 0, 6'h20, 0);
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int v = 0; v < 6; v++) begin
            seq = '0;
            seq[2:0] = vecs[v].idx;
            send_frame(vecs[v].n, seq, vecs[v].t0, vecs[v].t1);
            check_out($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].m8, vecs[v].e8, vecs[v].m6, vecs[v].e6);
            drain();
        end
        for (int b = 0; b < 17; b++) seq[b] = 3'(b % 8);
        send_frame(17, seq, 0, 0);
        check_out("sat", 4'd15, 8'h00, 0, 6'h00, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", b8.out_valid_o, 1);
            chk("stall_mask", b8.out_mask_o, 8'h00);
            chk("stall_count", b8.out_count_o, 4'd15);
            chk("stall_ready", b8.in_ready_o, 0);
        end
        drain();
        seq = '0;
        seq[0] = 3'd2;
        seq[1] = 3'd3;
        in_valid = 1'b1;
        target = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_index = seq[b];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_noframe", b8.out_valid_o, 0);
        end
        seq = '0;
        seq[2:0] = vecs[5].idx;
        send_frame(1, seq, 1, 1);
        check_out("postrst", 4'd1, 8'h80, 0, 6'h20, 0);
        drain();
`ifdef INDEX_MASK_BYPASS_EN
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        target = 1'b1;
        in_index = 3'd4;
        chk("byp_ready0", b8.in_ready_o, 1);
        @(posedge clk);
        #1;
        chk("byp_ready1", b8.in_ready_o, 1);
        chk("byp_mask_a8", b8.out_mask_o, 8'h08);
        chk("byp_mask_a6", b6.out_mask_o, 6'h02);
        chk("byp_valid_a", b8.out_valid_o, 1);
        in_index = 3'd1;
        @(posedge clk);
        #1;
        chk("byp_mask_b8", b8.out_mask_o, 8'h40);
        chk("byp_mask_b6", b6.out_mask_o, 6'h10);
        chk("byp_valid_b", b8.out_valid_o, 1);
        chk("byp_count_b", b8.out_count_o, 4'd1);
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk);
        #1;
        chk("byp_done", b8.out_valid_o, 0);
        out_ready = 1'b0;
`else
        seq = '0;
        seq[0] = 3'd4;
        send_frame(1, seq, 1, 1);
        chk("bubble_ready", b8.in_ready_o, 0);
        check_out("single4", 4'd1, 8'h08, 0, 6'h02, 0);
        drain();
        chk("bubble_ready_back", b8.in_ready_o, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/index_mask_builder.md
Name: index_mask_builder

Overview:
Decoder-direction counterpart of the team's MSB-first find-first priority encoder. Accepts a valid/ready stream of bit indices and builds one mask per frame, with the frame closed by a last flag. Each index k drives mask bit DATA_WIDTH-1-k to the frame's target polarity. Running find_first on the output mask with the same target therefore returns the smallest index in the frame. Used to rebuild thread/slot masks from serialised index lists.

Parameters:
DATA_WIDTH, 8, mask width in bits
DATA_DEPTH, 3, index width; 2^DATA_DEPTH >= DATA_WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  index beat valid
in_ready_o  output  1  index beat accepted when in_valid_i & in_ready_o
in_index_i  input  DATA_DEPTH  index; 0 = MSB (bit DATA_WIDTH-1)
in_last_i  input  1  final beat of frame
target_i  input  1  polarity written at indexed bits (1 = find-one, 0 = find-zero); sampled on first beat only
out_valid_o  output  1  frame mask available
out_ready_i  input  1  consumer accepts mask
out_mask_o  output  DATA_WIDTH  assembled mask
out_count_o  output  DATA_DEPTH+1  beats accepted in frame, saturating at all-ones
out_err_o  output  1  at least one index >= DATA_WIDTH seen in frame

Behaviour:
- Reset (async assert, sync-released by system): state=ACC, first=1, acc_mask=0, count=0, err=0; out_valid_o=0, out_mask_o=0, out_count_o=0, out_err_o=0.
- States:
  - ACC: in_ready_o=1, out_valid_o=0.
  - OUT: in_ready_o=0, out_valid_o=1.
- ACC, beat accepted, first=1:
  - latch tgt=target_i.
  - base = {DATA_WIDTH{~target_i}}, then apply the index to base.
  - count=1; err = (index >= DATA_WIDTH).
  - first cleared.
- ACC, beat accepted, first=0:
  - apply index to acc_mask using latched tgt; target_i ignored.
  - count+1, saturating at 2^(DATA_DEPTH+1)-1.
  - err |= out-of-range.
- Apply index: if in_index_i < DATA_WIDTH, bit DATA_WIDTH-1-in_index_i := tgt. Otherwise mask unchanged and err flagged.
- Duplicate indices: idempotent on the mask; count still increments.
- Beat with in_last_i:
  - out_mask_o/out_count_o/out_err_o get the updated values (including this beat) in the same edge.
  - ->OUT; out_valid_o rises the cycle after the last beat (1-cycle latency).
- OUT: outputs registered and stable until handshake. out_valid_o & out_ready_i -> ACC next cycle, first=1, count=0, err=0.
- out_valid_o never drops without a handshake; out_ready_i while in ACC is ignored.
- Throughput without the optional feature: one bubble cycle per frame (in_ready_o=0 during OUT).
- Reset mid-frame: partial frame discarded, no output produced.
- in_index_i/in_last_i/target_i ignored when no handshake occurs.

Optional Feature:
INDEX_MASK_BYPASS_EN
- Defined: in_ready_o = (state==ACC) | out_ready_i.
  - Beat accepted in OUT during the output handshake cycle starts a new frame (first-beat rules).
  - Single-beat frame (last=1) in that cycle keeps state OUT with the new mask.
  - Zero-bubble back-to-back frames.
- Undefined: behaviour exactly as above, one bubble per frame.

Test Plan:
- DATA_WIDTH=8, target=1, indices 0,3(last), out_ready=1 -> out_mask 0x90, count 2, err 0; out_valid one cycle after last beat.
- target=0, single beat index 7 last -> out_mask 0xFE, count 1. Then frame target=1, indices 2,2,5(last) -> 0x24, count 3 (duplicate idempotent).
- target_i toggled 1->0 on second beat, indices 1,6(last) -> 0x42, confirming tgt latched at first beat.
- DATA_WIDTH=6, DATA_DEPTH=3, target=1, indices 6,1(last) -> out_mask 6'b010000, err 1, count 2. Next frame index 0 -> err 0, mask 6'b100000.
- out_ready held 0 for 5 cycles after frame -> out_valid stays 1, mask/count stable, in_ready_o 0 (non-bypass). rst_n pulsed low mid-frame after 2 beats -> all outputs 0, no frame emitted.
- INDEX_MASK_BYPASS_EN, two single-beat frames (index 4, index 1) with out_ready=1 continuously -> in_ready_o never low, masks 0x08 then 0x40 on consecutive cycles.
